destuff_extract: RTL and testbench

Receive-side counterpart of the stuff/data slot scheduler. Consumes a framed slot stream of `pm` slots per frame, locally regenerates the same data/stuff pattern (slot j is data iff (j·cm) mod pm < cm), forwards only the `cm` data words, and discards stuff slots. It sits between the line-side slot deserializer and the payload sink.

---
 rtl/destuff_extract.sv | 102 ++++++++++
 tb/tb_destuff_extract.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/destuff_extract.sv
// Receive-side stuff removal: regenerates the (j*cm) mod pm < cm slot pattern and forwards only data slots.
// Optional DESTUFF_CHECK_EN adds truncated-frame, overrun and sof/slot-collision error detection.
module destuff_extract #(
  parameter int MPT_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MPT_W-1:0]  pm,
  input  logic [MPT_W-1:0]  cm,
  input  logic              sof,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] slot_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              last_out,
  output logic              ds_out,
  output logic              frame_done,
  output logic              err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q;
  logic [MPT_W-1:0] pm_q, cm_q, acc_q, cnt_q;
  logic [MPT_W:0]   sum;
  logic [MPT_W-1:0] nxt;
  logic             ds, last, bad_cfg, sof_err;
`ifdef DESTUFF_CHECK_EN
  logic             done_q;
`endif

  // acc < pm and cm <= pm, so a single conditional subtract keeps acc in range
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, cm_q};
    nxt     = (sum >= {1'b0, pm_q}) ? MPT_W'(sum - {1'b0, pm_q}) : sum[MPT_W-1:0];
    ds      = (nxt < cm_q);
    last    = (({1'b0, cnt_q} + (MPT_W+1)'(1)) == {1'b0, pm_q});
    bad_cfg = (pm < MPT_W'(2)) || (cm == '0) || (cm > pm);
`ifdef DESTUFF_CHECK_EN
    sof_err = bad_cfg || ((state_q == ACTIVE) && (cnt_q != '0)) || valid_in;
`else
    sof_err = bad_cfg;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pm_q       <= '0;
      cm_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      last_out   <= 1'b0;
      ds_out     <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
`ifdef DESTUFF_CHECK_EN
      done_q     <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      last_out   <= 1'b0;
      frame_done <= 1'b0;
      if (sof) begin
        pm_q    <= pm;
        cm_q    <= cm;
        acc_q   <= '0;
        cnt_q   <= '0;
        err     <= sof_err;
        state_q <= bad_cfg ? IDLE : ACTIVE;
`ifdef DESTUFF_CHECK_EN
        done_q  <= 1'b0;
`endif
      end else if (state_q == ACTIVE && valid_in) begin
        acc_q  <= nxt;
        cnt_q  <= cnt_q + MPT_W'(1);
        ds_out <= ds;
        if (ds) begin
          data_out   <= slot_in;
          data_valid <= 1'b1;
        end
        if (last) begin
          last_out   <= 1'b1;
          frame_done <= 1'b1;
          state_q    <= IDLE;
`ifdef DESTUFF_CHECK_EN
          done_q     <= 1'b1;
`endif
        end
      end
`ifdef DESTUFF_CHECK_EN
      else if (state_q == IDLE && valid_in && done_q) begin
        err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_destuff_extract.sv
// Directed bench for destuff_extract: pattern decode, gaps, back-to-back frames, errors, async reset.
module tb_destuff_extract;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] pm = '0, cm = '0, slot_in = '0;
  logic       sof = 1'b0, valid_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, last_out, ds_out, frame_done, err;
  int         tests = 0, fails = 0;
  int         dv_cnt, last_cnt, fd_cnt;
`ifdef DESTUFF_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  destuff_extract #(.MPT_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pm(pm), .cm(cm), .sof(sof), .valid_in(valid_in),
    .slot_in(slot_in), .data_out(data_out), .data_valid(data_valid), .last_out(last_out),
    .ds_out(ds_out), .frame_done(frame_done), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, let the edge consume them, land 1ns after the edge
  task automatic step(input logic s, input logic [7:0] p, input logic [7:0] c,
                      input logic v, input logic [7:0] d);
    sof = s; pm = p; cm = c; valid_in = v; slot_in = d;
    @(posedge clk); #1;
    sof = 1'b0; valid_in = 1'b0;
  endtask

  task automatic slot_chk(input string tag, input logic [7:0] d, input logic eds, input logic elast);
    step(1'b0, 8'd0, 8'd0, 1'b1, d);
    chk({tag, ".ds"}, ds_out, eds);
    chk({tag, ".dv"}, data_valid, eds);
    if (eds) chk({tag, ".dout"}, data_out, d);
    chk({tag, ".last"}, last_out, elast);
    chk({tag, ".fd"}, frame_done, elast);
  endtask

  initial begin
    #12;
    chk("rst.dout", data_out, 0);   chk("rst.dv", data_valid, 0);
    chk("rst.last", last_out, 0);   chk("rst.ds", ds_out, 0);
    chk("rst.fd", frame_done, 0);   chk("rst.err", err, 0);
    rst_n = 1'b1;

    // pm=5 cm=2: data at slots 3 and 5
    step(1'b1, 8'd5, 8'd2, 1'b0, 8'h00);
    chk("f5.sof.err", err, 0); chk("f5.sof.dv", data_valid, 0);
    slot_chk("f5.s1", 8'h11, 0, 0);
    slot_chk("f5.s2", 8'h12, 0, 0);
    slot_chk("f5.s3", 8'h13, 1, 0);
    slot_chk("f5.s4", 8'h14, 0, 0);
    chk("f5.hold", data_out, 8'h13);
    slot_chk("f5.s5", 8'h15, 1, 1);
    step(1'b0, 8'd0, 8'd0, 1'b0, 8'h00);
    chk("f5.fd_once", frame_done, 0);

    // pm=7 cm=3 with an idle gap after slot 2: data at 3,5,7
    step(1'b1, 8'd7, 8'd3, 1'b0, 8'h00);
    slot_chk("f7.s1", 8'h21, 0, 0);
    slot_chk("f7.s2", 8'h22, 0, 0);
    step(1'b0, 8'd0, 8'd0, 1'b0, 8'h00);
    chk("f7.gap.dv", data_valid, 0); chk("f7.gap.last", last_out, 0); chk("f7.gap.fd", frame_done, 0);
    slot_chk("f7.s3", 8'h23, 1, 0);
    slot_chk("f7.s4", 8'h24, 0, 0);
    slot_chk("f7.s5", 8'h25, 1, 0);
    slot_chk("f7.s6", 8'h26, 0, 0);
    slot_chk("f7.s7", 8'h27, 1, 1);

    // pm=4 cm=4 all data, then pm=200 cm=199 back-to-back
    step(1'b1, 8'd4, 8'd4, 1'b0, 8'h00);
    slot_chk("f4.s1", 8'h41, 1, 0);
    slot_chk("f4.s2", 8'h42, 1, 0);
    slot_chk("f4.s3", 8'h43, 1, 0);
    slot_chk("f4.s4", 8'h44, 1, 1);
    step(1'b1, 8'd200, 8'd199, 1'b0, 8'h00);
    dv_cnt = 0; last_cnt = 0; fd_cnt = 0;
    for (int j = 1; j <= 200; j++) begin
      step(1'b0, 8'd0, 8'd0, 1'b1, 8'(j));
      chk("f200.ds", ds_out, ((j * 199) % 200) < 199);
      dv_cnt += int'(data_valid); last_cnt += int'(last_out); fd_cnt += int'(frame_done);
      if (j == 200) begin
        chk("f200.last", last_out, 1); chk("f200.dout", data_out, 8'd200);
      end
    end
    chk("f200.dv_cnt", dv_cnt, 199); chk("f200.last_cnt", last_cnt, 1); chk("f200.fd_cnt", fd_cnt, 1);

    // bad config cm>pm
    step(1'b1, 8'd5, 8'd9, 1'b0, 8'h00);
    chk("bad.err", err, 1);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 8'd0, 8'd0, 1'b1, 8'h55);
      chk("bad.dv", data_valid, 0); chk("bad.fd", frame_done, 0);
    end
    chk("bad.sticky", err, 1);
    step(1'b1, 8'd5, 8'd2, 1'b0, 8'h00);
    chk("bad.clear", err, 0);

    // truncated frame after 3 of 5 slots, then a full frame, then an overrun slot
    slot_chk("tr.s1", 8'h61, 0, 0);
    slot_chk("tr.s2", 8'h62, 0, 0);
    slot_chk("tr.s3", 8'h63, 1, 0);
    step(1'b1, 8'd5, 8'd2, 1'b0, 8'h00);
    chk("tr.err", err, CHK);
    slot_chk("tr2.s1", 8'h71, 0, 0);
    slot_chk("tr2.s2", 8'h72, 0, 0);
    slot_chk("tr2.s3", 8'h73, 1, 0);
    slot_chk("tr2.s4", 8'h74, 0, 0);
    slot_chk("tr2.s5", 8'h75, 1, 1);
    chk("tr2.err", err, CHK);
    step(1'b0, 8'd0, 8'd0, 1'b1, 8'h76);
    chk("ovr.dv", data_valid, 0); chk("ovr.fd", frame_done, 0); chk("ovr.err", err, CHK);

    // sof and slot in the same cycle: slot discarded
    step(1'b1, 8'd5, 8'd2, 1'b1, 8'hAA);
    chk("col.err", err, CHK); chk("col.dv", data_valid, 0);
    slot_chk("col.s1", 8'h81, 0, 0);
    slot_chk("col.s2", 8'h82, 0, 0);
    slot_chk("col.s3", 8'h83, 1, 0);
    slot_chk("col.s4", 8'h84, 0, 0);
    slot_chk("col.s5", 8'h85, 1, 1);

    // async reset mid-frame, then slots without sof are ignored
    step(1'b1, 8'd5, 8'd2, 1'b0, 8'h00);
    slot_chk("rm.s1", 8'h91, 0, 0);
    slot_chk("rm.s2", 8'h92, 0, 0);
    slot_chk("rm.s3", 8'h93, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rm.dout", data_out, 0);  chk("rm.dv", data_valid, 0);
    chk("rm.last", last_out, 0);  chk("rm.ds", ds_out, 0);
    chk("rm.fd", frame_done, 0);  chk("rm.err", err, 0);
    #2 rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 8'd0, 8'd0, 1'b1, 8'hA0 + 8'(j));
      chk("post.dv", data_valid, 0); chk("post.fd", frame_done, 0); chk("post.ds", ds_out, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
